mips_multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS core. It replaces the single-cycle combinational decoder. The core shares one memory port for fetch and data, and one ALU for PC increment, address generation and execution. This block sequences the shared datapath one state per clock, from the instruction-register contents and the ALU zero flag. It also detects the all-zero halt word, flags unsupported encodings, and pulses retire once per completed instruction for the bench.

---
 rtl/mips_ctrl_pkg.sv | 50 +++++
 rtl/mips_alu_decoder.sv | 23 ++
 rtl/mips_multicycle_control.sv | 159 +++++++++++++++
 tb/tb_mips_multicycle_control.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        HALT    = 4'd12,
        ILLEGAL = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct decoder: ALU operation plus a flag marking supported encodings.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       supported
);

    always_comb begin
        alu_control = ALU_ADD;
        supported   = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: supported   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core: one state per clock, Moore
// outputs driving the shared memory port, ALU and register file.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic [1:0]  pc_src,
    output logic        pc_en,
    output logic        retire,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state_dbg
);

    state_t     state, state_next;
    logic [5:0] op;
    logic [2:0] fn_alu;
    logic       fn_ok;
    logic       pc_write, branch;

    assign op        = instr[31:26];
    assign state_dbg = state;

    mips_alu_decoder u_alu_dec (
        .funct       (instr[5:0]),
        .alu_control (fn_alu),
        .supported   (fn_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = FETCH;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        alu_control = ALU_AND;
        pc_src      = PCSRC_ALU;
        pc_write    = 1'b0;
        branch      = 1'b0;
        retire      = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (state)
            FETCH: begin
                ir_write    = 1'b1;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                pc_write    = 1'b1;
                state_next  = DECODE;
            end
            DECODE: begin
                // Branch target is computed here while the opcode is decoded.
                alu_src_b   = SRCB_IMM_SH;
                alu_control = ALU_ADD;
                if (instr == HALT_WORD)                   state_next = HALT;
                else if (op == OP_LW || op == OP_SW)      state_next = MEMADR;
                else if (op == OP_RTYPE && fn_ok)         state_next = EXECUTE;
                else if (op == OP_BEQ)                    state_next = BRANCH;
                else if (op == OP_ADDI)                   state_next = ADDIEX;
                else if (op == OP_J)                      state_next = JUMP;
                else                                      state_next = ILLEGAL;
            end
            MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                state_next  = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord       = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
            end
            EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = fn_alu;
                state_next  = ALUWB;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = PCSRC_ALUOUT;
                branch      = 1'b1;
                retire      = 1'b1;
            end
            ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                state_next  = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            HALT: begin
                halted     = 1'b1;
                state_next = HALT;
            end
            ILLEGAL: begin
                illegal    = 1'b1;
                state_next = ILLEGAL;
            end
            default: state_next = FETCH;
        endcase
        pc_en = pc_write | (branch & zero);
        // A reset cycle must never commit architectural state.
        if (reset) begin
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle control FSM: state sequences and control
// outputs for each instruction class, halt/illegal traps and mid-op reset.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic        alu_src_a, pc_en, retire, halted, illegal;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_control;
    logic [3:0]  state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    mips_multicycle_control #(.HALT_WORD(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_src(pc_src), .pc_en(pc_en), .retire(retire), .halted(halted),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int exp_st [6] = '{0, 1, 2, 3, 4, 0};
        reset = 1'b1; instr = 32'h8C01_0004; zero = 1'b0;
        repeat (2) begin
            step;
            tests_run++;
            if ({pc_en, ir_write, reg_write, mem_write} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_enables got=%b exp=0000", {pc_en, ir_write, reg_write, mem_write});
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (state_dbg !== exp_st[i][3:0] || reg_write !== (i == 4) || retire !== (i == 4)) begin
                tests_failed++;
                $display("FAIL lw_seq[%0d] state=%0d rw=%b ret=%b exp state=%0d rw/ret=%b",
                         i, state_dbg, reg_write, retire, exp_st[i], (i == 4));
            end
            if (i == 0) begin
                tests_run++;
                if ({ir_write, pc_en, iord, alu_src_a, alu_src_b, alu_control} !== {4'b1100, 2'b01, 3'b010}) begin
                    tests_failed++;
                    $display("FAIL fetch_outputs got=%b exp=110001010",
                             {ir_write, pc_en, iord, alu_src_a, alu_src_b, alu_control});
                end
            end
            if (i == 4) begin
                tests_run++;
                if (mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL memwb_mux m2r=%b rdst=%b exp 1 0", mem_to_reg, reg_dst);
                end
            end
            if (i < 5) step;
        end
    endtask

    task automatic test_rtype(input logic [31:0] ins, input logic [2:0] exp_alu);
        int exp_st [5] = '{0, 1, 6, 7, 0};
        instr = ins;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (state_dbg !== exp_st[i][3:0] || retire !== (i == 3)) begin
                tests_failed++;
                $display("FAIL rtype_seq[%0d] instr=%h state=%0d ret=%b exp state=%0d ret=%b",
                         i, ins, state_dbg, retire, exp_st[i], (i == 3));
            end
            if (i == 2) begin
                tests_run++;
                if (alu_control !== exp_alu || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL execute_alu instr=%h alu=%b srca=%b srcb=%b exp alu=%b 1 00",
                             ins, alu_control, alu_src_a, alu_src_b, exp_alu);
                end
            end
            if (i == 3) begin
                tests_run++;
                if (reg_dst !== 1'b1 || reg_write !== 1'b1 || mem_to_reg !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL aluwb rdst=%b rw=%b m2r=%b exp 1 1 0", reg_dst, reg_write, mem_to_reg);
                end
            end
            if (i < 4) step;
        end
    endtask

    task automatic test_branch(input logic z);
        int exp_st [4] = '{0, 1, 8, 0};
        instr = 32'h1022_0002;
        zero  = z;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (state_dbg !== exp_st[i][3:0]) begin
                tests_failed++;
                $display("FAIL beq_seq[%0d] zero=%b state=%0d exp=%0d", i, z, state_dbg, exp_st[i]);
            end
            if (i == 2) begin
                tests_run++;
                if (pc_en !== z || pc_src !== 2'b01 || alu_control !== 3'b110 || retire !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL beq_ctl zero=%b pc_en=%b pc_src=%b alu=%b ret=%b exp pc_en=%b 01 110 1",
                             z, pc_en, pc_src, alu_control, retire, z);
                end
            end
            if (i < 3) step;
        end
        zero = 1'b0;
    endtask

    task automatic test_sw;
        int exp_st [5] = '{0, 1, 2, 5, 0};
        int mw_cnt = 0;
        int rw_cnt = 0;
        instr = 32'hAC01_0008;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (state_dbg !== exp_st[i][3:0]) begin
                tests_failed++;
                $display("FAIL sw_seq[%0d] state=%0d exp=%0d", i, state_dbg, exp_st[i]);
            end
            if (mem_write === 1'b1) mw_cnt++;
            if (reg_write === 1'b1) rw_cnt++;
            if (i == 3) begin
                tests_run++;
                if (mem_write !== 1'b1 || iord !== 1'b1 || retire !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL memwr_ctl mw=%b iord=%b ret=%b exp 1 1 1", mem_write, iord, retire);
                end
            end
            if (i < 4) step;
        end
        tests_run++;
        if (mw_cnt != 1 || rw_cnt != 0) begin
            tests_failed++;
            $display("FAIL sw_counts mem_write=%0d reg_write=%0d exp 1 0", mw_cnt, rw_cnt);
        end
    endtask

    task automatic test_traps;
        instr = 32'h0000_0000;
        step; step;
        tests_run++;
        if (state_dbg !== 4'd12) begin
            tests_failed++;
            $display("FAIL halt_entry state=%0d exp=12", state_dbg);
        end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (halted !== 1'b1 || {pc_en, ir_write, reg_write, mem_write, retire} !== 5'b0) begin
                tests_failed++;
                $display("FAIL halt_hold[%0d] halted=%b en=%b exp 1 00000", i, halted,
                         {pc_en, ir_write, reg_write, mem_write, retire});
            end
            step;
        end
        reset = 1'b1; step; reset = 1'b0; #1;
        tests_run++;
        if (state_dbg !== 4'd0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_reset state=%0d halted=%b exp 0 0", state_dbg, halted);
        end
        instr = 32'h0000_003F;
        step; step;
        tests_run++;
        if (state_dbg !== 4'd13 || illegal !== 1'b1 || {pc_en, reg_write, mem_write} !== 3'b0) begin
            tests_failed++;
            $display("FAIL illegal_entry state=%0d illegal=%b en=%b exp 13 1 000", state_dbg, illegal,
                     {pc_en, reg_write, mem_write});
        end
        step;
        tests_run++;
        if (state_dbg !== 4'd13) begin
            tests_failed++;
            $display("FAIL illegal_hold state=%0d exp=13", state_dbg);
        end
        reset = 1'b1; step; reset = 1'b0; #1;
        tests_run++;
        if (state_dbg !== 4'd0 || illegal !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_reset state=%0d illegal=%b exp 0 0", state_dbg, illegal);
        end
    endtask

    task automatic test_reset_midop;
        int rw_cnt = 0;
        instr = 32'h8C01_0004;
        step; step; step;
        tests_run++;
        if (state_dbg !== 4'd3) begin
            tests_failed++;
            $display("FAIL midop_memrd state=%0d exp=3", state_dbg);
        end
        reset = 1'b1; #1;
        if (reg_write === 1'b1) rw_cnt++;
        step;
        if (reg_write === 1'b1) rw_cnt++;
        tests_run++;
        if (state_dbg !== 4'd0) begin
            tests_failed++;
            $display("FAIL midop_state state=%0d exp=0", state_dbg);
        end
        instr = 32'h1022_0002;
        reset = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            if (reg_write === 1'b1) rw_cnt++;
            step;
        end
        tests_run++;
        if (rw_cnt != 0) begin
            tests_failed++;
            $display("FAIL midop_no_write reg_write_cycles=%0d exp=0", rw_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_rtype(32'h0022_1820, 3'b010);
        test_rtype(32'h0022_182A, 3'b111);
        test_branch(1'b1);
        test_branch(1'b0);
        test_sw;
        test_traps;
        test_reset_midop;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
